bcd_display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller that shares one BCD_to_7segment decoder between NUM_DIGITS common-cathode digits. It holds a packed BCD word and presents one digit at a time on the decoder input. It drives a one-hot digit enable, with a blanking guard on every digit switch to prevent ghosting. New display words are double-buffered and take effect only at a frame boundary, so a frame never mixes old and new digits.

---
 rtl/bcd_display_scan_ctrl.sv | 125 ++++++++++++
 tb/tb_bcd_display_scan_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bcd_display_scan_ctrl.sv
// Time-multiplexed BCD scan controller with guard blanking and frame-boundary word swap.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module bcd_display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  output logic                    load_pending,
  output logic [0:3]              bcd,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] P_TC   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_GD   = PW'(GUARD_CYCLES);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    GUARD,
    SHOW
  } state_t;

  logic [DW-1:0] shadow;
  logic [DW-1:0] active;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  state_t        state;

  logic          tc;
  logic          boundary;
  logic [PW-1:0] presc_n;
  logic [IW-1:0] idx_n;
  logic [DW-1:0] active_n;
  logic [3:0]    nib_n;
  state_t        state_n;
  logic          lz_n;
  logic          blank_n;
  logic          fd_n;
  logic [NUM_DIGITS-1:0] en_n;

  // Outputs are registered from the values the counters take on this edge,
  // so every output lines up with the slot it describes.
  always_comb begin
    tc       = (presc == P_TC);
    boundary = tc && (idx == I_LAST);
    presc_n  = tc ? '0 : presc + PW'(1);
    idx_n    = idx;
    if (tc) idx_n = (idx == I_LAST) ? '0 : idx + IW'(1);
    active_n = (boundary && load_pending) ? shadow : active;
    nib_n    = active_n[4*int'(idx_n) +: 4];
    fd_n     = (presc_n == P_TC) && (idx_n == I_LAST);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      GUARD: if (presc_n >= P_GD) state_n = SHOW;
      SHOW:  if (tc) state_n = GUARD;
      default: state_n = GUARD;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A zero digit is dark only when every more significant digit is zero too.
  always_comb begin
    lz_n = (idx_n != '0) && (nib_n == 4'd0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k > int'(idx_n) && active_n[4*k +: 4] != 4'd0)
        lz_n = 1'b0;
    end
  end
`else
  assign lz_n = 1'b0;
`endif

  always_comb begin
    blank_n = (nib_n > 4'd9) || lz_n;
    en_n    = '0;
    if (state_n == SHOW && !blank_n)
      en_n = NUM_DIGITS'(1) << idx_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow       <= '0;
      active       <= '0;
      load_pending <= 1'b0;
    end else begin
      if (load) begin
        shadow       <= data_in;
        load_pending <= 1'b1;
      end else if (boundary) begin
        load_pending <= 1'b0;
      end
      active <= active_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      state      <= GUARD;
      bcd        <= 4'b0000;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      presc      <= presc_n;
      idx        <= idx_n;
      state      <= state_n;
      bcd        <= nib_n;
      digit_en   <= en_n;
      frame_done <= fd_n;
    end
  end

endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// Directed bench for bcd_display_scan_ctrl (4 digits, 8-cycle slots, 2 guard cycles).
// Expected words per frame are written by hand; per-cycle enables follow from them.
module tb_bcd_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic        load_pending;
  logic [0:3]  bcd;
  logic [3:0]  digit_en;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_pend = 1'b0;

  bcd_display_scan_ctrl #(
    .NUM_DIGITS(4),
    .REFRESH_DIV(8),
    .GUARD_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .data_in(data_in),
    .load_pending(load_pending),
    .bcd(bcd),
    .digit_en(digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_en(input logic [15:0] w,
                                        input int k, input int c);
    logic [3:0] nib;
    logic       dark;
    nib  = w[4*k +: 4];
    dark = (nib > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
    if (k != 0 && (w >> (4*k)) == 16'h0) dark = 1'b1;
`endif
    if (c < 2 || dark) return 4'b0000;
    return 4'(1 << k);
  endfunction

  // Start at cycle 0 of slot 0; check ncyc cycles of a frame showing w,
  // optionally pulsing load at cycle indices la and lb.
  task automatic check_frame(input logic [15:0] w,
                             input int la, input logic [15:0] da,
                             input int lb, input logic [15:0] db,
                             input int ncyc);
    int s, c;
    logic [3:0] nib;
    for (int n = 0; n < ncyc; n++) begin
      s   = n / 8;
      c   = n % 8;
      nib = w[4*s +: 4];
      load    = (n == la) || (n == lb);
      data_in = (n == lb) ? db : da;
      chk($sformatf("en %h s%0d c%0d", w, s, c), 32'(digit_en),
          32'(exp_en(w, s, c)));
      chk($sformatf("bcd %h s%0d c%0d", w, s, c), 32'(bcd), 32'(nib));
      chk($sformatf("fd %h n%0d", w, n), 32'(frame_done),
          32'(n == 31));
      chk($sformatf("pend %h n%0d", w, n), 32'(load_pending),
          32'(exp_pend));
      tick();
      if (load) exp_pend = 1'b1;
      else if (n == 31) exp_pend = 1'b0;
    end
    load = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    data_in = 16'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst en", 32'(digit_en), 32'h0);
      chk("rst bcd", 32'(bcd), 32'h0);
      chk("rst fd", 32'(frame_done), 32'h0);
    end
    rst = 1'b0;

    // idle scan, then a single load mid-frame
    check_frame(16'h0000, -1, 16'h0, -1, 16'h0, 32);
    check_frame(16'h0000, 10, 16'h1234, -1, 16'h0, 32);
    // double load: last write wins
    check_frame(16'h1234, 5, 16'h1111, 20, 16'h5678, 32);
    // load on the frame_done cycle while 4321 is pending
    check_frame(16'h5678, 3, 16'h4321, 31, 16'h9999, 32);
    chk("pend after bnd", 32'(load_pending), 32'h1);
    check_frame(16'h4321, -1, 16'h0, -1, 16'h0, 32);
    check_frame(16'h9999, 0, 16'h12A4, -1, 16'h0, 32);
    // invalid nibble in digit 1
    check_frame(16'h12A4, -1, 16'h0, -1, 16'h0, 32);
    // reset during digit 2 SHOW with a word pending
    check_frame(16'h12A4, 5, 16'h0042, -1, 16'h0, 21);
    chk("pre-rst en", 32'(digit_en), 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("async en", 32'(digit_en), 32'h0);
    chk("async pend", 32'(load_pending), 32'h0);
    chk("async bcd", 32'(bcd), 32'h0);
    exp_pend = 1'b0;
    tick();
    rst = 1'b0;
    check_frame(16'h0000, 0, 16'h0042, -1, 16'h0, 32);
    check_frame(16'h0042, -1, 16'h0, -1, 16'h0, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
